// File: rtl/fp16_mult_collector.sv
// fp16_mult_collector
//   Feeds operand pairs to an external, fixed-latency, non-stallable FP16
//   multiplier. It collects each product and its exception flags into a
//   result FIFO, and presents them downstream in issue order.
//
//   Because the multiplier cannot stall, an operand pair is only accepted
//   when the FIFO has room for it. The space is counted as buffered entries
//   plus products still in the multiplier pipeline.
//
// Parameters
//   DWIDTH   operand/result width
//   LATENCY  multiplier latency; an issue at edge T is captured at edge T+LATENCY
//   DEPTH    result FIFO entries; must be at least LATENCY+2 for full throughput
//
// Ports
//   clk, rst                 clock, synchronous active-low reset
//   in_valid/in_ready        operand handshake, in_a/in_b operands
//   mult_a/mult_b            operands to multiplier (zero when not issuing)
//   mult_result/mult_flags   multiplier product and exception flags
//   out_valid/out_ready      result handshake, out_result/out_flags FIFO head
//   sticky_clr/exc_sticky    sticky OR of captured flags and its clear
//   result_cnt               number of results popped (wrapping)
module fp16_mult_collector #(
    parameter int DWIDTH  = 16,
    parameter int LATENCY = 5,
    parameter int DEPTH   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DWIDTH-1:0] in_a,
    input  logic [DWIDTH-1:0] in_b,
    output logic [DWIDTH-1:0] mult_a,
    output logic [DWIDTH-1:0] mult_b,
    input  logic [DWIDTH-1:0] mult_result,
    input  logic [4:0]        mult_flags,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DWIDTH-1:0] out_result,
    output logic [4:0]        out_flags,
    input  logic              sticky_clr,
    output logic [4:0]        exc_sticky,
    output logic [15:0]       result_cnt
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(DEPTH + LATENCY + 1);

    logic [LATENCY-1:0] r_vld_sr;
    logic [PW-1:0]      r_wptr;
    logic [PW-1:0]      r_rptr;
    logic [CW-1:0]      r_count;
    logic [DWIDTH-1:0]  r_mem_res [DEPTH];
    logic [4:0]         r_mem_flg [DEPTH];
    logic [4:0]         r_sticky;
    logic [15:0]        r_result_cnt;

    logic [SW-1:0]      w_inflight;
    logic [SW-1:0]      w_used;
    logic               w_issue;
    logic               w_capture;
    logic               w_pop;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PW-1:0] f_ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < LATENCY; i++) begin
            w_inflight = w_inflight + SW'(r_vld_sr[i]);
        end
    end

    // Credit uses the registered occupancy only, so a pop in this cycle
    // frees space no earlier than the next cycle.
    assign w_used     = SW'(r_count) + w_inflight;
    assign in_ready   = rst & (w_used < SW'(DEPTH));
    assign w_issue    = in_valid & in_ready;
    assign w_capture  = r_vld_sr[LATENCY-1];

    assign mult_a     = w_issue ? in_a : '0;
    assign mult_b     = w_issue ? in_b : '0;

    assign out_valid  = rst & (r_count != '0);
    assign w_pop      = out_valid & out_ready;
    assign out_result = r_mem_res[r_rptr];
    assign out_flags  = r_mem_flg[r_rptr];
    assign exc_sticky = r_sticky;
    assign result_cnt = r_result_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_vld_sr     <= '0;
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_count      <= '0;
            r_sticky     <= '0;
            r_result_cnt <= '0;
        end else begin
            r_vld_sr <= (r_vld_sr << 1) | LATENCY'(w_issue);
            if (w_capture) begin
                r_wptr <= f_ptr_inc(r_wptr);
            end
            if (w_pop) begin
                r_rptr       <= f_ptr_inc(r_rptr);
                r_result_cnt <= r_result_cnt + 16'd1;
            end
            case ({w_capture, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            // A clear coinciding with a capture keeps that capture's flags.
            if (sticky_clr) begin
                r_sticky <= w_capture ? mult_flags : 5'd0;
            end else if (w_capture) begin
                r_sticky <= r_sticky | mult_flags;
            end
        end
    end

    // Storage carries no reset; validity is tracked by the pointers/occupancy.
    always_ff @(posedge clk) begin
        if (rst && w_capture) begin
            r_mem_res[r_wptr] <= mult_result;
            r_mem_flg[r_wptr] <= mult_flags;
        end
    end

endmodule

// File: doc/fp16_mult_collector.md
FP16_MULT_COLLECTOR -- requirements
Module: fp16_mult_collector

Interface
REQ-001 Parameter DWIDTH, default 16, width of one FP operand/result (sign+exponent+mantissa).
REQ-002 Parameter LATENCY, default 5, fixed cycle latency of the attached non-stallable FP16 multiplier: an operand pair sampled at edge T gives a result at the multiplier output after edge T+4, stable until edge T+5.
REQ-003 Parameter DEPTH, default 8, result FIFO entries; DEPTH SHALL be >= LATENCY+2.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-low reset.
REQ-006 in_valid  input  1  upstream operand pair present.
REQ-007 in_ready  output  1  collector can accept an operand pair this cycle.
REQ-008 in_a, in_b  input  DWIDTH each  operands.
REQ-009 mult_a, mult_b  output  DWIDTH each  operands driven to the multiplier.
REQ-010 mult_result  input  DWIDTH  multiplier product.
REQ-011 mult_flags  input  5  multiplier exception flags.
REQ-012 out_valid  output  1  FIFO head valid.
REQ-013 out_ready  input  1  downstream accepts head.
REQ-014 out_result  output  DWIDTH  FIFO head product.
REQ-015 out_flags  output  5  FIFO head flags.
REQ-016 sticky_clr  input  1  clear sticky exception register.
REQ-017 exc_sticky  output  5  bitwise OR of flags of all captured results since last clear/reset.
REQ-018 result_cnt  output  16  count of results popped downstream, wraps 0xFFFF->0x0000.

Function
REQ-019 Issue = in_valid & in_ready; mult_a/mult_b SHALL equal in_a/in_b in an issue cycle and 0 otherwise (combinational).
REQ-020 A LATENCY-bit valid shift register SHALL shift every cycle, bit 0 loaded with issue; the top bit marks a capture at the current edge.
REQ-021 Capture: when the top bit is set, mult_result and mult_flags SHALL be written into the FIFO tail at that edge.
REQ-022 Issue at edge T SHALL be captured at edge T+LATENCY; out_valid rises no earlier than LATENCY+1 cycles after the issue cycle.
REQ-023 Results SHALL leave in issue order; no result dropped, duplicated or reordered.
REQ-024 in_ready = (occupancy + in-flight count) < DEPTH; in-flight = popcount of the shift register; a same-cycle pop SHALL NOT give credit.
REQ-025 With out_ready held 1, sustained throughput SHALL be one issue per cycle.
REQ-026 Pop = out_valid & out_ready; out_* present head combinationally from FIFO storage; values held stable while out_valid & ~out_ready.
REQ-027 Simultaneous capture and pop: occupancy unchanged, pointers both advance, modulo DEPTH wrap.
REQ-028 Pop with FIFO empty impossible (out_valid=0); capture into a full FIFO impossible by REQ-024.
REQ-029 exc_sticky: on sticky_clr, register cleared; on capture, OR in mult_flags; both in one cycle -> register = mult_flags of that capture.
REQ-030 result_cnt SHALL increment by 1 on every pop.

Reset
REQ-031 While rst=0 at an edge: shift register, FIFO pointers, occupancy, exc_sticky, result_cnt cleared to 0.
REQ-032 During/after reset: out_valid=0, in_ready=1 (rst deasserted), mult_a/mult_b=0 unless issuing.
REQ-033 Reset mid-operation SHALL discard all in-flight and buffered results; multiplier outputs arriving afterwards for pre-reset issues SHALL be ignored.
REQ-034 Issue SHALL be suppressed (in_ready forced 0) in any cycle where rst=0.

Verification
REQ-035 Single op, bench drives the team FP16 multiplier: in_a=0x3C00, in_b=0x4000 at cycle 0 -> out_valid at cycle 6, out_result=0x4000, out_flags=0, result_cnt=1 after pop.
REQ-036 Back-to-back 20 issues of 0x3E00*0x3E00, out_ready=1 -> in_ready never deasserts after fill, 20 results 0x4080 in consecutive cycles, result_cnt=20.
REQ-037 Backpressure: out_ready=0, in_valid=1 continuously -> exactly DEPTH=8 issues accepted, in_ready=0 thereafter, occupancy 8; release out_ready -> 8 results in order, then issue resumes.
REQ-038 Sticky: capture with mult_flags=0b10010 then 0b00001 -> exc_sticky=0b10011; sticky_clr in capture cycle of flags 0b00100 -> exc_sticky=0b00100.
REQ-039 Reset mid-stream: 3 ops in flight, 2 buffered, rst=0 one cycle -> out_valid=0, result_cnt=0, no stale result ever appears.
REQ-040 Pointer wrap: 3*DEPTH ops with random out_ready -> order and values match scoreboard, no overflow.
